spi_regfile: RTL and testbench
==============================

Name: spi_regfile

Overview:
Parametrised SPI mode-0 slave exposing a bank of NUM_REGS read/write configuration registers of DATA_W bits each. All SPI inputs are oversampled and synchronised into the system clock domain, so every internal flop runs on clk. It supersedes the fixed five-register write-only SPI block: the register count and data width are parametrised, it adds readback on sdo, and it reports framing errors. It sits between the chip pins and the peripheral blocks that consume the configuration registers.

Parameters:
NUM_REGS, 5, number of registers; valid addresses are 0..NUM_REGS-1 (NUM_REGS <= 2**ADDR_W)
DATA_W, 8, register width in bits
ADDR_W, 7, address field width
SYNC_STAGES, 2, synchroniser depth on sclk/sdi/cs (>= 2)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
sclk  input  1  SPI clock, idle low, asynchronous to clk
sdi  input  1  SPI data in, MSB first
cs  input  1  chip select, active low
sdo  output  1  SPI data out, registered, never tri-stated
regs  output  NUM_REGS*DATA_W  flattened register bank; reg k at [k*DATA_W +: DATA_W]
wr_strobe  output  1  one-clk pulse when a write commits
wr_addr  output  ADDR_W  address of the last committed write
frame_err  output  1  one-clk pulse when a frame is discarded
busy  output  1  high while synchronised cs is low

Behaviour:
- Clocking: one clock (clk); reset is asynchronous and active-low (rst_n). Reset clears regs, sdo, wr_strobe, wr_addr, frame_err, busy, the bit counter and the shift registers to 0. Reset mid-frame discards the frame; the next frame starts clean.
- Frame: F = 1+ADDR_W+DATA_W bits (16 at defaults). Bit 0 is R/W (1 = write), then the address MSB first, then the data MSB first.
- Sampling: sclk, sdi and cs each pass through SYNC_STAGES flops. Edges are detected on the synchronised sclk against a one-flop delayed copy. A rise samples sdi into the shift register and increments the bit counter. The counter saturates at F+1.
- Timing requirement: the sclk high and low phases are each >= 4 clk periods, and cs high time is >= 4 clk. Faster input is outside the supported range.
- Frame start: the synchronised cs falling edge clears the counter and the shift register and sets busy.
- Read path: at the rise that completes the address (count reaches 1+ADDR_W) with R/W=0, load the out-shifter with reg[addr], or 0 if addr >= NUM_REGS. On each subsequent synchronised sclk fall, drive the next data bit MSB first onto sdo. Outside the data phase of a read, sdo = 0. sdo lags the real sclk fall by <= SYNC_STAGES+2 clk.
- Commit: on the synchronised cs rising edge, busy drops. One clk later, exactly one of the following applies:
  - count == F, R/W=1, addr < NUM_REGS: reg[addr] <= data; wr_addr <= addr; wr_strobe=1 for 1 clk.
  - count == F, R/W=0: no register change, no pulse.
  - any other case (count != F, or a write to addr >= NUM_REGS): no change; frame_err=1 for 1 clk.
- Registers not addressed keep their values. Reads are non-destructive.
- Glitch rule: sclk edges seen while synchronised cs is high are ignored.
- regs are readable at all times. A write is visible on regs in the same cycle wr_strobe is high.
- Block size: 120-400 lines of RTL.

Test Plan:
1. Write: frame 0x82A5 (write, addr 2, data 0xA5) with sclk = clk/10 -> regs[2]=0xA5 one clk after sync cs rise; wr_strobe single pulse; wr_addr=2; all other regs stay 0; frame_err stays 0.
2. Readback: after test 1, send frame 0x0200 -> sdo shows 1,0,1,0,0,1,0,1 sampled on sclk rises 9..16; sdo=0 during bits 1..8; regs unchanged; no wr_strobe.
3. Errors: 15-bit write frame, 17-bit write frame, and write to addr 7 (0x8733) -> each gives one frame_err pulse; regs unchanged. Read of addr 6 returns 0x00 on sdo.
4. Abort: cs raised after 10 bits of 0x83FF -> frame_err pulse, reg3 unchanged. Next full frame 0x83FF -> reg3=0xFF.
5. Reset: rst_n pulsed low mid-frame after regs loaded -> all regs=0, sdo=0, busy=0 immediately (asynchronously). Following valid write frame commits normally.
6. Parametrised instance: NUM_REGS=8, DATA_W=16, ADDR_W=3, F=20 -> write 0xBEEF to addr 7, then read back 0xBEEF on sdo; write to addr 0 leaves addr 7 intact.

Source files
------------

// File: rtl/spi_regfile.sv
// -----------------------------------------------------------------------------
// spi_regfile
//
// SPI mode-0 slave fronting a bank of NUM_REGS read/write configuration
// registers, DATA_W bits each. Every SPI pin is oversampled into the clk
// domain, so the whole block is a single-clock design.
//
// Frame (F = 1 + ADDR_W + DATA_W bits, MSB first on sdi):
//   bit 0            : R/W (1 = write, 0 = read)
//   next ADDR_W bits : register address
//   last DATA_W bits : write data (ignored for reads)
//
// Handshake: the frame is delimited by cs (active low). A write is applied
// one clk after the synchronised cs rising edge, and only when exactly F bits
// were clocked in and the address is in range. wr_strobe and the new regs value
// appear in the same cycle. Any frame that does not qualify as a full write or
// a full read raises frame_err for one clk instead.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   sclk       SPI clock (idle low, asynchronous to clk)
//   sdi        SPI serial data in
//   cs         SPI chip select, active low
//   sdo        SPI serial data out, registered, driven during a read data phase
//   regs       flattened register bank, reg k at [k*DATA_W +: DATA_W]
//   wr_strobe  one-clk pulse when a write commits
//   wr_addr    address of the last committed write
//   frame_err  one-clk pulse when a frame is discarded
//   busy       high while synchronised cs is low
// -----------------------------------------------------------------------------
module spi_regfile #(
    parameter int NUM_REGS    = 5,
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 7,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         sclk,
    input  logic                         sdi,
    input  logic                         cs,
    output logic                         sdo,
    output logic [NUM_REGS*DATA_W-1:0]   regs,
    output logic                         wr_strobe,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic                         frame_err,
    output logic                         busy
);

    localparam int F     = 1 + ADDR_W + DATA_W;
    localparam int CNT_W = $clog2(F + 2);

    // Bit-count milestones. CNT_ADDR is the count just before the rise that
    // completes the address field.
    localparam logic [CNT_W-1:0] CNT_ADDR      = CNT_W'(ADDR_W);
    localparam logic [CNT_W-1:0] CNT_ADDR_DONE = CNT_W'(1 + ADDR_W);
    localparam logic [CNT_W-1:0] CNT_FULL      = CNT_W'(F);
    localparam logic [CNT_W-1:0] CNT_SAT       = CNT_W'(F + 1);

    // One extra bit so NUM_REGS == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0]  NUM_REGS_W    = (ADDR_W + 1)'(NUM_REGS);

    // -------------------------------------------------------------------------
    // Input synchronisers and edge detection
    // -------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] sdi_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic                   sclk_d;
    logic                   cs_d;

    logic sclk_s;
    logic sdi_s;
    logic cs_s;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign sdi_s  = sdi_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];

    // The cs chain resets to the idle (high) level. If cs is already high when
    // reset releases there is no phantom edge, and a frame that was cut by
    // reset cannot produce a spurious commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            sdi_sync  <= '0;
            cs_sync   <= '1;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], sdi};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
            sclk_d    <= sclk_s;
            cs_d      <= cs_s;
        end
    end

    logic sclk_rise;
    logic sclk_fall;
    logic cs_fall;
    logic cs_rise;

    // sclk activity is only meaningful while the slave is selected.
    assign sclk_rise = sclk_s & ~sclk_d & ~cs_s;
    assign sclk_fall = ~sclk_s & sclk_d & ~cs_s;
    assign cs_fall   = ~cs_s & cs_d;
    assign cs_rise   = cs_s & ~cs_d;

    // -------------------------------------------------------------------------
    // Register bank storage
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] reg_q [NUM_REGS];

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs
        assign regs[k*DATA_W +: DATA_W] = reg_q[k];
    end

    // -------------------------------------------------------------------------
    // Frame receive / read shifter
    // -------------------------------------------------------------------------
    logic [F-1:0]      frame_sr;
    logic [F-1:0]      frame_next;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] out_sr;
    logic              read_act;
    logic              commit_pend;

    assign frame_next = {frame_sr[F-2:0], sdi_s};

    // On the rise that completes the address, frame_next holds {rw, addr} in
    // its low bits.
    logic              rx_rw;
    logic [ADDR_W-1:0] rx_addr;
    logic [DATA_W-1:0] rd_word;

    assign rx_rw   = frame_next[ADDR_W];
    assign rx_addr = frame_next[ADDR_W-1:0];

    // Out-of-range addresses read back as zero.
    always_comb begin
        rd_word = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (rx_addr == ADDR_W'(k)) begin
                rd_word = reg_q[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_sr    <= '0;
            bit_cnt     <= '0;
            out_sr      <= '0;
            read_act    <= 1'b0;
            commit_pend <= 1'b0;
            busy        <= 1'b0;
            sdo         <= 1'b0;
        end else begin
            commit_pend <= 1'b0;
            if (cs_fall) begin
                frame_sr <= '0;
                bit_cnt  <= '0;
                read_act <= 1'b0;
                busy     <= 1'b1;
                sdo      <= 1'b0;
            end else if (cs_rise) begin
                // bit_cnt and frame_sr are frozen while cs is high, so the
                // commit logic can inspect them on the following clk.
                busy        <= 1'b0;
                commit_pend <= 1'b1;
                read_act    <= 1'b0;
                sdo         <= 1'b0;
            end else begin
                if (sclk_rise) begin
                    if (bit_cnt < CNT_FULL) begin
                        frame_sr <= frame_next;
                    end
                    if (bit_cnt != CNT_SAT) begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    if (bit_cnt == CNT_ADDR && !rx_rw) begin
                        out_sr   <= rd_word;
                        read_act <= 1'b1;
                    end
                end
                // A fall after rise k presents the bit the master samples at
                // rise k+1; data bits belong to rises 2+ADDR_W .. F.
                if (sclk_fall) begin
                    if (read_act && bit_cnt >= CNT_ADDR_DONE && bit_cnt < CNT_FULL) begin
                        sdo    <= out_sr[DATA_W-1];
                        out_sr <= out_sr << 1;
                    end else begin
                        sdo <= 1'b0;
                    end
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Commit
    // -------------------------------------------------------------------------
    logic              cm_rw;
    logic [ADDR_W-1:0] cm_addr;
    logic [DATA_W-1:0] cm_data;
    logic              cm_addr_ok;
    logic              cm_full;

    assign cm_rw      = frame_sr[F-1];
    assign cm_addr    = frame_sr[F-2 -: ADDR_W];
    assign cm_data    = frame_sr[DATA_W-1:0];
    assign cm_addr_ok = {1'b0, cm_addr} < NUM_REGS_W;
    assign cm_full    = (bit_cnt == CNT_FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                reg_q[k] <= '0;
            end
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            frame_err <= 1'b0;
        end else begin
            wr_strobe <= 1'b0;
            frame_err <= 1'b0;
            if (commit_pend) begin
                if (cm_full && cm_rw && cm_addr_ok) begin
                    for (int k = 0; k < NUM_REGS; k++) begin
                        if (cm_addr == ADDR_W'(k)) begin
                            reg_q[k] <= cm_data;
                        end
                    end
                    wr_addr   <= cm_addr;
                    wr_strobe <= 1'b1;
                end else if (!(cm_full && !cm_rw)) begin
                    // Short, long or aborted frame, or a write out of range.
                    frame_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_regfile.sv
// -----------------------------------------------------------------------------
// tb_spi_regfile
//
// Self-checking bench for spi_regfile. Two instances share sclk/sdi/rst_n and
// have separate chip selects: dut_a uses default parameters, dut_b uses
// NUM_REGS=8, DATA_W=16, ADDR_W=3 (F=20). sclk runs at clk/10.
// -----------------------------------------------------------------------------
module tb_spi_regfile;

  localparam int NA = 5;
  localparam int DA = 8;
  localparam int AA = 7;
  localparam int FA = 1 + AA + DA;
  localparam int NB = 8;
  localparam int DB = 16;
  localparam int AB = 3;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sclk = 1'b0;
  logic sdi = 1'b0;
  logic cs_a = 1'b1;
  logic cs_b = 1'b1;

  logic             sdo_a, sdo_b;
  logic [NA*DA-1:0] regs_a;
  logic [NB*DB-1:0] regs_b;
  logic             wr_strobe_a, wr_strobe_b;
  logic             frame_err_a, frame_err_b;
  logic             busy_a, busy_b;
  logic [AA-1:0]    wr_addr_a;
  logic [AB-1:0]    wr_addr_b;

  always #5 clk = ~clk;

  spi_regfile dut_a (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .sdi(sdi), .cs(cs_a),
    .sdo(sdo_a), .regs(regs_a), .wr_strobe(wr_strobe_a), .wr_addr(wr_addr_a),
    .frame_err(frame_err_a), .busy(busy_a)
  );

  spi_regfile #(.NUM_REGS(NB), .DATA_W(DB), .ADDR_W(AB), .SYNC_STAGES(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .sdi(sdi), .cs(cs_b),
    .sdo(sdo_b), .regs(regs_b), .wr_strobe(wr_strobe_b), .wr_addr(wr_addr_b),
    .frame_err(frame_err_b), .busy(busy_b)
  );

  // ---------------------------------------------------------------------------
  // Check bookkeeping
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Pulse monitor: counts strobe cycles and captures the addressed register
  // during the strobe cycle.
  int wr_cnt_a = 0;
  int err_cnt_a = 0;
  int wr_cnt_b = 0;
  int err_cnt_b = 0;
  logic [DA-1:0] strobe_data_a;
  logic [DB-1:0] strobe_data_b;

  always @(negedge clk) begin
    if (wr_strobe_a === 1'b1) begin
      wr_cnt_a++;
      strobe_data_a = regs_a[int'(wr_addr_a)*DA +: DA];
    end
    if (frame_err_a === 1'b1) err_cnt_a++;
    if (wr_strobe_b === 1'b1) begin
      wr_cnt_b++;
      strobe_data_b = regs_b[int'(wr_addr_b)*DB +: DB];
    end
    if (frame_err_b === 1'b1) err_cnt_b++;
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (inputs change on negedge clk; sdo sampled at the sclk rise)
  // ---------------------------------------------------------------------------
  task automatic send_bits(input int inst, input int nbits, input logic [31:0] bits,
                           output logic [31:0] sdo_bits);
    sdo_bits = '0;
    for (int i = nbits - 1; i >= 0; i--) begin
      sdi = bits[i];
      repeat (5) @(negedge clk);
      sclk = 1'b1;
      sdo_bits = {sdo_bits[30:0], (inst == 0) ? sdo_a : sdo_b};
      repeat (5) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic spi_xfer(input int inst, input int nbits, input logic [31:0] bits,
                          output logic [31:0] sdo_bits);
    if (inst == 0) cs_a = 1'b0; else cs_b = 1'b0;
    repeat (6) @(negedge clk);
    send_bits(inst, nbits, bits, sdo_bits);
    repeat (5) @(negedge clk);
    if (inst == 0) cs_a = 1'b1; else cs_b = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model for dut_a: register array plus frame rules
  // ---------------------------------------------------------------------------
  logic [DA-1:0] model_a [NA];
  logic [AA-1:0] model_wr_addr;

  function automatic logic [NA*DA-1:0] model_bus();
    logic [NA*DA-1:0] b;
    b = '0;
    for (int k = 0; k < NA; k++) b[k*DA +: DA] = model_a[k];
    return b;
  endfunction

  // Bit j (1-based, in transmit order) of a frame is bits[nbits-j].
  task automatic model_frame(input int nbits, input logic [31:0] bits,
                             output int exp_wr, output int exp_err,
                             output logic [31:0] exp_sdo, output logic [DA-1:0] exp_data);
    int rw;
    int addr;
    int last;
    logic [DA-1:0] data;
    logic [DA-1:0] rd;
    exp_wr = 0;
    exp_err = 0;
    exp_sdo = '0;
    rw = int'(bits[nbits-1]);
    addr = 0;
    for (int j = 2; j <= 1 + AA; j++) if (j <= nbits) addr = addr * 2 + int'(bits[nbits-j]);
    data = '0;
    for (int j = 2 + AA; j <= FA; j++) if (j <= nbits) data = {data[DA-2:0], bits[nbits-j]};
    exp_data = data;
    if (rw == 0 && nbits >= 1 + AA) begin
      rd = (addr < NA) ? model_a[addr] : '0;
      last = (nbits < FA) ? nbits : FA;
      for (int j = 2 + AA; j <= last; j++) exp_sdo[nbits-j] = rd[DA-1-(j-2-AA)];
    end
    if (nbits == FA && rw == 1 && addr < NA) begin
      model_a[addr] = data;
      model_wr_addr = AA'(addr);
      exp_wr = 1;
    end else if (!(nbits == FA && rw == 0)) begin
      exp_err = 1;
    end
  endtask

  int obs_wr;
  int obs_err;
  logic [31:0] obs_sdo;

  task automatic run_a(input string tag, input int nbits, input logic [31:0] bits);
    int w0, e0, exp_wr, exp_err;
    logic [31:0] exp_sdo;
    logic [DA-1:0] exp_data;
    w0 = wr_cnt_a;
    e0 = err_cnt_a;
    model_frame(nbits, bits, exp_wr, exp_err, exp_sdo, exp_data);
    spi_xfer(0, nbits, bits, obs_sdo);
    obs_wr = wr_cnt_a - w0;
    obs_err = err_cnt_a - e0;
    check({tag, "_wr_pulses"}, 64'(obs_wr), 64'(exp_wr));
    check({tag, "_err_pulses"}, 64'(obs_err), 64'(exp_err));
    check({tag, "_sdo"}, 64'(obs_sdo), 64'(exp_sdo));
    check({tag, "_regs"}, 64'(regs_a), 64'(model_bus()));
    check({tag, "_wr_addr"}, 64'(wr_addr_a), 64'(model_wr_addr));
    check({tag, "_busy"}, 64'(busy_a), 64'(0));
    if (exp_wr == 1) check({tag, "_strobe_data"}, 64'(strobe_data_a), 64'(exp_data));
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    int          nbits;
    logic [31:0] bits;
    int          exp_wr;
    int          exp_err;
    logic [31:0] exp_sdo;
    int          chk_idx;
    logic [7:0]  chk_val;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [31:0] sb;
    int w0, e0, nb, len_sel;
    logic [31:0] rb;
    int lens[7];

    vecs[0] = '{16, 32'h82A5,  1, 0, 32'h0000, 2, 8'hA5};  // write reg2 = A5
    vecs[1] = '{16, 32'h0200,  0, 0, 32'h00A5, 2, 8'hA5};  // read reg2
    vecs[2] = '{15, 32'h4152,  0, 1, 32'h0000, 2, 8'hA5};  // 15-bit write
    vecs[3] = '{17, 32'h1054B, 0, 1, 32'h0000, 2, 8'hA5};  // 17-bit write
    vecs[4] = '{16, 32'h8733,  0, 1, 32'h0000, 2, 8'hA5};  // write addr 7
    vecs[5] = '{16, 32'h0600,  0, 0, 32'h0000, 0, 8'h00};  // read addr 6
    vecs[6] = '{10, 32'h020F,  0, 1, 32'h0000, 3, 8'h00};  // abort after 10
    vecs[7] = '{16, 32'h83FF,  1, 0, 32'h0000, 3, 8'hFF};  // write reg3 = FF
    vecs[8] = '{16, 32'h0300,  0, 0, 32'h00FF, 3, 8'hFF};  // read reg3

    for (int k = 0; k < NA; k++) model_a[k] = '0;
    model_wr_addr = '0;

    // Reset values
    repeat (4) @(negedge clk);
    check("rst_regs", 64'(regs_a), 64'(0));
    check("rst_sdo", 64'(sdo_a), 64'(0));
    check("rst_busy", 64'(busy_a), 64'(0));
    check("rst_wr_addr", 64'(wr_addr_a), 64'(0));
    check("rst_wr_strobe", 64'(wr_strobe_a), 64'(0));
    check("rst_frame_err", 64'(frame_err_a), 64'(0));
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Busy follows cs
    cs_a = 1'b0;
    repeat (6) @(negedge clk);
    check("busy_high", 64'(busy_a), 64'(1));
    cs_a = 1'b1;
    repeat (8) @(negedge clk);
    model_frame(0 + 1, 32'h0, nb, len_sel, rb, strobe_data_a);  // model bookkeeping for an empty frame is not used
    w0 = err_cnt_a;

    // Table
    for (int i = 0; i < 9; i++) begin
      run_a($sformatf("vec%0d", i), vecs[i].nbits, vecs[i].bits);
      check($sformatf("vec%0d_tbl_wr", i), 64'(obs_wr), 64'(vecs[i].exp_wr));
      check($sformatf("vec%0d_tbl_err", i), 64'(obs_err), 64'(vecs[i].exp_err));
      check($sformatf("vec%0d_tbl_sdo", i), 64'(obs_sdo), 64'(vecs[i].exp_sdo));
      check($sformatf("vec%0d_tbl_reg", i), 64'(regs_a[vecs[i].chk_idx*DA +: DA]),
            64'(vecs[i].chk_val));
    end

    // Reset mid-frame during the data phase of a read of reg2 (A5)
    w0 = wr_cnt_a;
    e0 = err_cnt_a;
    cs_a = 1'b0;
    repeat (6) @(negedge clk);
    send_bits(0, 8, 32'h02, sb);
    repeat (5) @(negedge clk);
    check("midread_sdo_msb", 64'(sdo_a), 64'(1));
    check("midread_busy", 64'(busy_a), 64'(1));
    rst_n = 1'b0;
    #1;
    check("async_rst_regs", 64'(regs_a), 64'(0));
    check("async_rst_sdo", 64'(sdo_a), 64'(0));
    check("async_rst_busy", 64'(busy_a), 64'(0));
    cs_a = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("rst_window_wr", 64'(wr_cnt_a - w0), 64'(0));
    check("rst_window_err", 64'(err_cnt_a - e0), 64'(0));
    for (int k = 0; k < NA; k++) model_a[k] = '0;
    model_wr_addr = '0;
    run_a("post_rst_write", 16, 32'h8155);

    // Randomized frames against the model
    lens = '{10, 15, 16, 16, 16, 16, 17};
    for (int i = 0; i < 30; i++) begin
      len_sel = $urandom_range(0, 6);
      nb = lens[len_sel];
      if (nb == 16) begin
        rb = ({31'd0, 1'($urandom_range(0, 1))} << 15) | (32'($urandom_range(0, 7)) << 8)
             | 32'($urandom_range(0, 255));
      end else begin
        rb = $urandom & ((32'd1 << nb) - 32'd1);
      end
      run_a($sformatf("rnd%0d", i), nb, rb);
    end

    // Parametrised instance: F = 20
    w0 = wr_cnt_b;
    e0 = err_cnt_b;
    spi_xfer(1, 20, 32'hFBEEF, sb);
    check("b_wr7_pulses", 64'(wr_cnt_b - w0), 64'(1));
    check("b_wr7_strobe_data", 64'(strobe_data_b), 64'(16'hBEEF));
    check("b_wr7_addr", 64'(wr_addr_b), 64'(7));
    check("b_reg7", 64'(regs_b[7*DB +: DB]), 64'(16'hBEEF));
    spi_xfer(1, 20, 32'h70000, sb);
    check("b_rd7_sdo", 64'(sb), 64'(32'h0BEEF));
    spi_xfer(1, 20, 32'h81234, sb);
    check("b_wr0_pulses", 64'(wr_cnt_b - w0), 64'(2));
    check("b_wr0_addr", 64'(wr_addr_b), 64'(0));
    check("b_reg0", 64'(regs_b[0 +: DB]), 64'(16'h1234));
    check("b_reg7_kept", 64'(regs_b[7*DB +: DB]), 64'(16'hBEEF));
    check("b_mid_regs", 64'(regs_b[DB +: 64]), 64'(0));
    check("b_err_pulses", 64'(err_cnt_b - e0), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
